// File: rtl/ace_controller_fsm_pkg.sv
// ace_controller_fsm_pkg
//  Shared types for the ACE master-port control FSM:
//   ace_state_e - controller states
//   ace_ctl_t   - bundle of every control output, built in one place by the
//                 next-state logic and fanned out to ports by the top
package ace_controller_fsm_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_ADDR   = 4'd1,
    WR_DATA   = 4'd2,
    WR_RESP   = 4'd3,
    RD_ADDR   = 4'd4,
    RD_RESP   = 4'd5,
    MU_ADDR   = 4'd6,
    MU_RESP   = 4'd7,
    SN_LOOKUP = 4'd8,
    SN_CR     = 4'd9,
    SN_CD     = 4'd10
  } ace_state_e;

  typedef struct packed {
    logic ace_ready;
    logic write_clean;
    logic read_shared;
    logic make_unique;
    logic read_resp_en;
    logic ac_enable;
    logic aw_valid;
    logic w_valid;
    logic b_ready;
    logic ar_valid;
    logic r_ready;
    logic ac_ready;
    logic cr_valid;
    logic cd_valid;
  } ace_ctl_t;

  // True for states that own an outstanding master transaction.
  function automatic logic is_master_state(input ace_state_e s);
    return (s inside {WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_RESP, MU_ADDR, MU_RESP});
  endfunction

endpackage

// File: rtl/ace_controller_fsm_if.sv
// ace_controller_fsm_if
//  ACE channel handshakes between the cache controller and the interconnect.
//  Only VALID/READY plus the decoded OKAY flags travel here; addresses and
//  data stay in the cache datapath.
//   master : controller side (drives AW/W/AR VALID, B/R READY, AC READY,
//            CR/CD VALID)
//   slave  : interconnect side
interface ace_controller_fsm_if;
  logic AW_VALID, AW_READY;
  logic W_VALID,  W_READY;
  logic B_VALID,  B_READY, B_okay;
  logic AR_VALID, AR_READY;
  logic R_VALID,  R_READY, R_okay;
  logic AC_VALID, AC_READY;
  logic CR_VALID, CR_READY;
  logic CD_VALID, CD_READY;

  modport master (
    output AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, AC_READY, CR_VALID, CD_VALID,
    input  AW_READY, W_READY, B_VALID, B_okay, AR_READY, R_VALID, R_okay,
           AC_VALID, CR_READY, CD_READY
  );

  modport slave (
    input  AW_VALID, W_VALID, B_READY, AR_VALID, R_READY, AC_READY, CR_VALID, CD_VALID,
    output AW_READY, W_READY, B_VALID, B_okay, AR_READY, R_VALID, R_okay,
           AC_VALID, CR_READY, CD_READY
  );
endinterface

// File: rtl/ace_controller_fsm.sv
// ace_controller_fsm
//  Control FSM of the cache's ACE master port. Converts datapath requests
//  into ACE transactions and serves incoming snoops:
//   write_req   -> WriteClean (AW, W, B)
//   read_req    -> ReadShared (AR, R)
//   invalid_req -> MakeUnique (AR, R, no data)
//   AC snoop    -> lookup, CR response, optional CD data
//  Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   read_req/write_req/invalid_req  datapath requests (sampled in IDLE only)
//   ace_ready                   idle, a request will be taken
//   invalid/snoop_miss/response/response_data  snoop lookup result
//   make_unique_o/read_shared_o/write_clean_o  datapath command select
//   read_resp_en                capture R data (OKAY ReadShared beat)
//   ac_enable                   capture AC address, start snoop lookup
//   ace                         ACE handshakes (master modport)
//  Non-OKAY B/R responses restart the transaction from its address phase.
import ace_controller_fsm_pkg::*;

module ace_controller_fsm (
  input  logic clk,
  input  logic rst_n,
  input  logic read_req,
  input  logic write_req,
  input  logic invalid_req,
  output logic ace_ready,
  input  logic invalid,
  input  logic snoop_miss,
  input  logic response,
  input  logic response_data,
  output logic make_unique_o,
  output logic read_shared_o,
  output logic write_clean_o,
  output logic read_resp_en,
  output logic ac_enable,
  ace_controller_fsm_if.master ace
);

  ace_state_e state_q, state_d;
  logic       sn_data_q, sn_data_d;  // snoop must follow CR with CD
  ace_ctl_t   ctl;
  logic       any_req;

  assign any_req = write_req | read_req | invalid_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sn_data_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sn_data_q <= sn_data_d;
    end
  end

  // Next state and outputs. While reset is held every output is forced low,
  // so nothing escapes even before the first reset edge lands.
  always_comb begin
    ctl       = '0;
    state_d   = state_q;
    sn_data_d = sn_data_q;
    if (!rst_n) begin
      state_d   = IDLE;
      sn_data_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ctl.ace_ready = 1'b1;
          // A request in the same cycle wins; the snoop stays pending on AC.
          ctl.ac_ready  = !any_req;
          if (write_req)          state_d = WR_ADDR;
          else if (read_req)      state_d = RD_ADDR;
          else if (invalid_req)   state_d = MU_ADDR;
          else if (ace.AC_VALID) begin
            ctl.ac_enable = 1'b1;
            state_d       = SN_LOOKUP;
          end
        end
        WR_ADDR: begin
          ctl.aw_valid    = 1'b1;
          ctl.write_clean = 1'b1;
          if (ace.AW_READY) state_d = WR_DATA;
        end
        WR_DATA: begin
          ctl.w_valid     = 1'b1;
          ctl.write_clean = 1'b1;
          if (ace.W_READY) state_d = WR_RESP;
        end
        WR_RESP: begin
          ctl.b_ready = 1'b1;
          if (ace.B_VALID) state_d = ace.B_okay ? IDLE : WR_ADDR;
        end
        RD_ADDR: begin
          ctl.ar_valid    = 1'b1;
          ctl.read_shared = 1'b1;
          if (ace.AR_READY) state_d = RD_RESP;
        end
        RD_RESP: begin
          ctl.r_ready = 1'b1;
          if (ace.R_VALID) begin
            if (ace.R_okay) begin
              ctl.read_resp_en = 1'b1;
              state_d          = IDLE;
            end else begin
              state_d = RD_ADDR;
            end
          end
        end
        MU_ADDR: begin
          ctl.ar_valid    = 1'b1;
          ctl.make_unique = 1'b1;
          if (ace.AR_READY) state_d = MU_RESP;
        end
        MU_RESP: begin
          ctl.r_ready = 1'b1;
          if (ace.R_VALID) state_d = ace.R_okay ? IDLE : MU_ADDR;
        end
        SN_LOOKUP: begin
          // Miss/invalid outranks a stray hit indication: no data to return.
          if (snoop_miss | invalid) begin
            sn_data_d = 1'b0;
            state_d   = SN_CR;
          end else if (response) begin
            sn_data_d = response_data;
            state_d   = SN_CR;
          end
        end
        SN_CR: begin
          ctl.cr_valid = 1'b1;
          if (ace.CR_READY) state_d = sn_data_q ? SN_CD : IDLE;
        end
        SN_CD: begin
          ctl.cd_valid = 1'b1;
          if (ace.CD_READY) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ace_ready     = ctl.ace_ready;
  assign write_clean_o = ctl.write_clean;
  assign read_shared_o = ctl.read_shared;
  assign make_unique_o = ctl.make_unique;
  assign read_resp_en  = ctl.read_resp_en;
  assign ac_enable     = ctl.ac_enable;
  assign ace.AW_VALID  = ctl.aw_valid;
  assign ace.W_VALID   = ctl.w_valid;
  assign ace.B_READY   = ctl.b_ready;
  assign ace.AR_VALID  = ctl.ar_valid;
  assign ace.R_READY   = ctl.r_ready;
  assign ace.AC_READY  = ctl.ac_ready;
  assign ace.CR_VALID  = ctl.cr_valid;
  assign ace.CD_VALID  = ctl.cd_valid;

endmodule

// File: tb/tb_ace_controller_fsm.sv
// Directed bench for ace_controller_fsm. All controller outputs are packed
// into one 14-bit vector and compared against hand-built masks.
import ace_controller_fsm_pkg::*;

module tb_ace_controller_fsm;

  logic clk = 1'b0;
  logic rst_n;
  logic read_req, write_req, invalid_req, ace_ready;
  logic invalid, snoop_miss, response, response_data;
  logic make_unique_o, read_shared_o, write_clean_o, read_resp_en, ac_enable;

  int checks = 0;
  int errors = 0;

  ace_controller_fsm_if ace ();

  ace_controller_fsm dut (
    .clk(clk), .rst_n(rst_n),
    .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
    .ace_ready(ace_ready),
    .invalid(invalid), .snoop_miss(snoop_miss), .response(response),
    .response_data(response_data),
    .make_unique_o(make_unique_o), .read_shared_o(read_shared_o),
    .write_clean_o(write_clean_o), .read_resp_en(read_resp_en),
    .ac_enable(ac_enable),
    .ace(ace.master)
  );

  always #5 clk = ~clk;

  localparam logic [13:0] RDY = 14'h2000, WC = 14'h1000, RS = 14'h0800, MU = 14'h0400,
                          RRE = 14'h0200, ACE = 14'h0100, AW = 14'h0080, W  = 14'h0040,
                          BR  = 14'h0020, AR  = 14'h0010, RR = 14'h0008, ACR = 14'h0004,
                          CR  = 14'h0002, CD  = 14'h0001;

  logic [13:0] outs;
  assign outs = {ace_ready, write_clean_o, read_shared_o, make_unique_o, read_resp_en, ac_enable,
                 ace.AW_VALID, ace.W_VALID, ace.B_READY, ace.AR_VALID, ace.R_READY,
                 ace.AC_READY, ace.CR_VALID, ace.CD_VALID};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [13:0] exp);
    #1;
    checks++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, outs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {read_req, write_req, invalid_req, invalid, snoop_miss, response, response_data} = '0;
    {ace.AW_READY, ace.W_READY, ace.B_VALID, ace.B_okay, ace.AR_READY, ace.R_VALID,
     ace.R_okay, ace.AC_VALID, ace.CR_READY, ace.CD_READY} = '0;
    write_req = 1'b1;
    chk("reset_pre_edge", '0);
    tick(); tick();
    chk("reset_held", '0);
    write_req = 1'b0;
    rst_n = 1'b1;
    chk("idle", RDY | ACR);

    // WriteClean: AW held without READY, retry on non-OKAY B
    write_req = 1'b1;
    chk("idle_wreq", RDY);
    tick(); write_req = 1'b0;
    chk("wr_addr", WC | AW);
    tick();
    chk("wr_addr_hold", WC | AW);
    ace.AW_READY = 1'b1; tick(); ace.AW_READY = 1'b0;
    chk("wr_data", WC | W);
    ace.W_READY = 1'b1; tick(); ace.W_READY = 1'b0;
    read_req = 1'b1;
    chk("wr_resp", BR);
    tick(); read_req = 1'b0;
    chk("wr_resp_req_ignored", BR);
    ace.B_VALID = 1'b1; ace.B_okay = 1'b0; tick(); ace.B_VALID = 1'b0;
    chk("wr_retry_aw", WC | AW);
    ace.AW_READY = 1'b1; tick(); ace.AW_READY = 1'b0;
    ace.W_READY = 1'b1; tick(); ace.W_READY = 1'b0;
    chk("wr_retry_resp", BR);
    ace.B_VALID = 1'b1; ace.B_okay = 1'b1; tick(); ace.B_VALID = 1'b0; ace.B_okay = 1'b0;
    chk("wr_done_idle", RDY | ACR);

    // ReadShared with AC_VALID pending throughout: request wins, snoop waits
    read_req = 1'b1; ace.AC_VALID = 1'b1;
    chk("idle_rreq_vs_ac", RDY);
    tick(); read_req = 1'b0;
    chk("rd_addr", RS | AR);
    ace.AR_READY = 1'b1; tick(); ace.AR_READY = 1'b0;
    chk("rd_resp_wait", RR);
    ace.R_VALID = 1'b1; ace.R_okay = 1'b0;
    chk("rd_resp_nok", RR);
    tick(); ace.R_VALID = 1'b0;
    chk("rd_retry_ar", RS | AR);
    ace.AR_READY = 1'b1; tick(); ace.AR_READY = 1'b0;
    ace.R_VALID = 1'b1; ace.R_okay = 1'b1;
    chk("rd_resp_accept", RR | RRE);
    tick(); ace.R_VALID = 1'b0; ace.R_okay = 1'b0;

    // Pending snoop now accepted; miss path, CR only
    chk("idle_ac_accept", RDY | ACR | ACE);
    tick(); ace.AC_VALID = 1'b0;
    chk("sn_lookup", '0);
    tick();
    chk("sn_lookup_wait", '0);
    snoop_miss = 1'b1; tick(); snoop_miss = 1'b0;
    chk("sn_cr_miss", CR);
    tick();
    chk("sn_cr_hold", CR);
    ace.CR_READY = 1'b1; tick(); ace.CR_READY = 1'b0;
    chk("sn_miss_no_cd", RDY | ACR);

    // MakeUnique with one non-OKAY retry; never read_resp_en
    invalid_req = 1'b1; tick(); invalid_req = 1'b0;
    chk("mu_addr", MU | AR);
    ace.AR_READY = 1'b1; tick(); ace.AR_READY = 1'b0;
    ace.R_VALID = 1'b1; ace.R_okay = 1'b0;
    chk("mu_resp_nok", RR);
    tick(); ace.R_VALID = 1'b0;
    chk("mu_retry_ar", MU | AR);
    ace.AR_READY = 1'b1; tick(); ace.AR_READY = 1'b0;
    ace.R_VALID = 1'b1; ace.R_okay = 1'b1;
    chk("mu_resp_ok_no_rre", RR);
    tick(); ace.R_VALID = 1'b0; ace.R_okay = 1'b0;
    chk("mu_done_idle", RDY | ACR);

    // Snoop hit with data, CR_READY delayed 4 cycles, CD_READY delayed 1
    ace.AC_VALID = 1'b1;
    chk("hit_ac_accept", RDY | ACR | ACE);
    tick(); ace.AC_VALID = 1'b0;
    response = 1'b1; response_data = 1'b1; tick(); response = 1'b0; response_data = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hit_cr_hold", CR);
      tick();
    end
    ace.CR_READY = 1'b1; tick(); ace.CR_READY = 1'b0;
    chk("hit_cd", CD);
    tick();
    chk("hit_cd_hold", CD);
    ace.CD_READY = 1'b1; tick(); ace.CD_READY = 1'b0;
    chk("hit_done_idle", RDY | ACR);

    // Hit without data: CR then straight to IDLE
    ace.AC_VALID = 1'b1; tick(); ace.AC_VALID = 1'b0;
    response = 1'b1; tick(); response = 1'b0;
    ace.CR_READY = 1'b1;
    chk("hit_nodata_cr", CR);
    tick(); ace.CR_READY = 1'b0;
    chk("hit_nodata_idle", RDY | ACR);

    // Invalid line with response_data set: still no CD
    ace.AC_VALID = 1'b1; tick(); ace.AC_VALID = 1'b0;
    invalid = 1'b1; response = 1'b1; response_data = 1'b1; tick();
    invalid = 1'b0; response = 1'b0; response_data = 1'b0;
    ace.CR_READY = 1'b1; tick(); ace.CR_READY = 1'b0;
    chk("inv_no_cd", RDY | ACR);

    // All three requests at once: write wins; then reset mid-transaction
    {write_req, read_req, invalid_req} = 3'b111; tick();
    {write_req, read_req, invalid_req} = 3'b000;
    chk("prio_write", WC | AW);
    rst_n = 1'b0;
    chk("mid_reset_outs", '0);
    tick(); rst_n = 1'b1;
    chk("mid_reset_idle", RDY | ACR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
